// File: rtl/stopwatch_bcd_counter_pkg.sv
// ============================================================================
// Package   : timer_pkg
// Purpose   : Shared widths, digit moduli and digit indices for the stopwatch
//             BCD time counter.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 7;

  localparam int MOD_DEC  = 10;
  localparam int MOD_SEXT = 6;

  localparam int DIG_MS1   = 0;
  localparam int DIG_MS10  = 1;
  localparam int DIG_MS100 = 2;
  localparam int DIG_S1    = 3;
  localparam int DIG_S10   = 4;
  localparam int DIG_M1    = 5;
  localparam int DIG_M10   = 6;

  typedef logic [BCD_W*NUM_DIGITS-1:0] time_bcd_t;

  // Only the tens-of-seconds digit is sexagesimal; every other digit is decimal.
  function automatic int digit_modulus(input int idx);
    return (idx == DIG_S10) ? MOD_SEXT : MOD_DEC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// ============================================================================
// Module    : bcd_digit
// Purpose   : One BCD digit of the time counter; counts modulo MODULUS and
//             signals a carry when an increment rolls it over.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import timer_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] val,
  output logic             carry
);

  localparam logic [BCD_W-1:0] c_TERM = BCD_W'(MODULUS - 1);

  logic [BCD_W-1:0] r_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
    end else if (clr) begin
      r_val <= '0;
    end else if (inc) begin
      r_val <= (r_val == c_TERM) ? '0 : r_val + 1'b1;
    end
  end

  assign val   = r_val;
  assign carry = inc & (r_val == c_TERM);

endmodule

`default_nettype wire

// File: rtl/stopwatch_bcd_counter.sv
// ============================================================================
// Module    : stopwatch_bcd_counter
// Purpose   : Prescaled millisecond counter holding elapsed time as packed BCD
//             MM:SS.mmm, with ms tick and wrap pulses. Optional lap hold when
//             STOPWATCH_LAP_EN is defined.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_bcd_counter
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        msclk,
  input  logic        reset,
  input  logic        cen,
  input  logic        clr,
  input  logic        lap,
  output logic [27:0] time_bcd,
  output logic        ms_tick,
  output logic        wrap
);

  localparam int           c_PRE_W    = 10;
  localparam logic [9:0]   c_PRE_TERM = c_PRE_W'(PRESCALE - 1);

  logic [c_PRE_W-1:0]  r_presc;
  logic                w_fire;
  logic [NUM_DIGITS:0] w_inc;
  time_bcd_t           w_run;

  assign w_fire = cen & (r_presc == c_PRE_TERM);

  // A paused prescaler keeps its partial count so the next ms is not lost.
  always_ff @(posedge msclk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (cen) begin
      r_presc <= w_fire ? '0 : r_presc + 1'b1;
    end
  end

  assign w_inc[0] = w_fire;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit #(
        .MODULUS (digit_modulus(gi))
      ) u_digit (
        .clk   (msclk),
        .rst   (reset),
        .inc   (w_inc[gi]),
        .clr   (clr),
        .val   (w_run[gi*BCD_W +: BCD_W]),
        .carry (w_inc[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge msclk) begin
    if (reset || clr) begin
      ms_tick <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      ms_tick <= w_fire;
      wrap    <= w_inc[NUM_DIGITS];
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic      r_lap_prev;
  logic      r_hold;
  time_bcd_t r_hold_val;

  // The frozen value is the one on display when the lap edge is sampled.
  always_ff @(posedge msclk) begin
    if (reset) begin
      r_lap_prev <= 1'b0;
      r_hold     <= 1'b0;
      r_hold_val <= '0;
    end else begin
      r_lap_prev <= lap;
      if (clr) begin
        r_hold <= 1'b0;
      end else if (lap && !r_lap_prev) begin
        r_hold <= ~r_hold;
        if (!r_hold) begin
          r_hold_val <= w_run;
        end
      end
    end
  end

  assign time_bcd = r_hold ? r_hold_val : w_run;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign time_bcd     = w_run;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_bcd_counter.sv
// ============================================================================
// Module    : tb_stopwatch_bcd_counter
// Purpose   : Self-checking bench for stopwatch_bcd_counter (PRESCALE 1 and 4)
//             against an elapsed-milliseconds reference model.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_bcd_counter;

  localparam int MS_MAX = 5999999;

  logic        msclk = 1'b0;
  logic        reset, cen, clr, lap;
  logic [27:0] t1, t4;
  logic        tk1, tk4, wr1, wr4;
  logic [27:0] pre_v;

  int n_vec = 0;
  int n_err = 0;

  always #5 msclk = ~msclk;

  stopwatch_bcd_counter #(.PRESCALE(1)) dut1 (
    .msclk(msclk), .reset(reset), .cen(cen), .clr(clr), .lap(lap),
    .time_bcd(t1), .ms_tick(tk1), .wrap(wr1)
  );

  stopwatch_bcd_counter #(.PRESCALE(4)) dut4 (
    .msclk(msclk), .reset(reset), .cen(cen), .clr(clr), .lap(lap),
    .time_bcd(t4), .ms_tick(tk4), .wrap(wr4)
  );

  // Reference model: elapsed time as plain integer milliseconds per instance.
  int m_ms[2];
  int m_pre[2];
  int m_holdv[2];
  bit m_tick[2];
  bit m_wrap[2];
  bit m_hold[2];
  bit m_lapprev;

  function automatic int presc_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [27:0] to_bcd(input int ms);
    int mm, ss, fr;
    mm = ms / 60000;
    ss = (ms / 1000) % 60;
    fr = ms % 1000;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            4'(fr / 100), 4'((fr / 10) % 10), 4'(fr % 10)};
  endfunction

  function automatic logic [27:0] exp_t(input int k);
    return m_hold[k] ? to_bcd(m_holdv[k]) : to_bcd(m_ms[k]);
  endfunction

  task automatic step();
    int old;
    @(posedge msclk);
    for (int k = 0; k < 2; k++) begin
      old       = m_ms[k];
      m_tick[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (reset || clr) begin
        m_ms[k]   = 0;
        m_pre[k]  = 0;
        m_hold[k] = 1'b0;
      end else begin
        if (cen) begin
          if (m_pre[k] == presc_of(k) - 1) begin
            m_pre[k]  = 0;
            m_tick[k] = 1'b1;
            if (m_ms[k] == MS_MAX) begin
              m_ms[k]   = 0;
              m_wrap[k] = 1'b1;
            end else begin
              m_ms[k] = m_ms[k] + 1;
            end
          end else begin
            m_pre[k] = m_pre[k] + 1;
          end
        end
`ifdef STOPWATCH_LAP_EN
        if (lap && !m_lapprev) begin
          if (m_hold[k]) begin
            m_hold[k] = 1'b0;
          end else begin
            m_hold[k]  = 1'b1;
            m_holdv[k] = old;
          end
        end
`endif
      end
    end
    m_lapprev = reset ? 1'b0 : lap;
    #1;
  endtask

  // Loads the PRESCALE=1 instance directly to a given time (its prescaler is always 0).
  task automatic preload(input int ms);
    pre_v = to_bcd(ms);
    @(negedge msclk);
    force dut1.g_digit[0].u_digit.r_val = pre_v[3:0];
    force dut1.g_digit[1].u_digit.r_val = pre_v[7:4];
    force dut1.g_digit[2].u_digit.r_val = pre_v[11:8];
    force dut1.g_digit[3].u_digit.r_val = pre_v[15:12];
    force dut1.g_digit[4].u_digit.r_val = pre_v[19:16];
    force dut1.g_digit[5].u_digit.r_val = pre_v[23:20];
    force dut1.g_digit[6].u_digit.r_val = pre_v[27:24];
    #1;
    release dut1.g_digit[0].u_digit.r_val;
    release dut1.g_digit[1].u_digit.r_val;
    release dut1.g_digit[2].u_digit.r_val;
    release dut1.g_digit[3].u_digit.r_val;
    release dut1.g_digit[4].u_digit.r_val;
    release dut1.g_digit[5].u_digit.r_val;
    release dut1.g_digit[6].u_digit.r_val;
    m_ms[0] = ms;
  endtask

  task automatic do_clear();
    clr = 1'b1; cen = 1'b0; lap = 1'b0;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cen = 1'b1; clr = 1'b0; lap = 1'b0;
    step();
    step();
    reset = 1'b0;
    n_vec++;
    if (t1 !== 28'h0 || t4 !== 28'h0) begin
      n_err++; $display("FAIL reset_time: got %h/%h, want 0000000/0000000", t1, t4);
    end
    n_vec++;
    if ({tk1, wr1, tk4, wr4} !== 4'b0) begin
      n_err++; $display("FAIL reset_pulses: got %b, want 0000", {tk1, wr1, tk4, wr4});
    end
  endtask

  task automatic test_count();
    int ticks = 0;
    cen = 1'b1;
    repeat (5) begin
      step();
      ticks += int'(tk1);
    end
    n_vec++;
    if (t1 !== 28'h0000005) begin
      n_err++; $display("FAIL count5_time: got %h, want 0000005", t1);
    end
    n_vec++;
    if (ticks != 5) begin
      n_err++; $display("FAIL count5_ticks: got %0d, want 5", ticks);
    end
    n_vec++;
    if (t4 !== 28'h0000001) begin
      n_err++; $display("FAIL count5_presc4: got %h, want 0000001", t4);
    end
  endtask

  task automatic test_carry_minute();
    do_clear();
    preload(59990);
    cen = 1'b1;
    repeat (9) step();
    n_vec++;
    if (t1 !== 28'h0059999) begin
      n_err++; $display("FAIL carry_pre: got %h, want 0059999", t1);
    end
    step();
    n_vec++;
    if (t1 !== 28'h0100000 || tk1 !== 1'b1 || wr1 !== 1'b0) begin
      n_err++; $display("FAIL carry_minute: got %h tick=%b wrap=%b, want 0100000 1 0", t1, tk1, wr1);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    preload(MS_MAX - 1);
    cen = 1'b1;
    step();
    n_vec++;
    if (t1 !== 28'h9959999 || wr1 !== 1'b0) begin
      n_err++; $display("FAIL wrap_pre: got %h wrap=%b, want 9959999 0", t1, wr1);
    end
    step();
    n_vec++;
    if (t1 !== 28'h0000000 || tk1 !== 1'b1 || wr1 !== 1'b1) begin
      n_err++; $display("FAIL wrap_roll: got %h tick=%b wrap=%b, want 0000000 1 1", t1, tk1, wr1);
    end
    cen = 1'b0;
    step();
    n_vec++;
    if (wr1 !== 1'b0 || tk1 !== 1'b0) begin
      n_err++; $display("FAIL wrap_width: got tick=%b wrap=%b, want 0 0", tk1, wr1);
    end
  endtask

  task automatic test_prescale();
    bit pat[7] = '{1, 1, 0, 0, 0, 1, 1};
    int ticks = 0;
    int at = -1;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      cen = pat[i];
      step();
      if (tk4) begin
        ticks++;
        at = i;
      end
    end
    n_vec++;
    if (ticks != 1 || at != 6 || t4 !== 28'h0000001) begin
      n_err++; $display("FAIL presc_pause: got ticks=%0d at=%0d t=%h, want 1 6 0000001", ticks, at, t4);
    end
  endtask

  task automatic test_clear_reset();
    do_clear();
    cen = 1'b1;
    repeat (123) step();
    n_vec++;
    if (t1 !== 28'h0000123) begin
      n_err++; $display("FAIL clr_setup: got %h, want 0000123", t1);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_vec++;
    if (t1 !== 28'h0 || tk1 !== 1'b0 || t4 !== 28'h0) begin
      n_err++; $display("FAIL clr_cen: got %h tick=%b t4=%h, want 0 0 0", t1, tk1, t4);
    end
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (t1 !== 28'h0 || {tk1, wr1, tk4, wr4} !== 4'b0) begin
      n_err++; $display("FAIL reset_mid: got %h pulses=%b, want 0 0000", t1, {tk1, wr1, tk4, wr4});
    end
    repeat (3) step();
    n_vec++;
    if (t4 !== 28'h0 || tk4 !== 1'b0) begin
      n_err++; $display("FAIL reset_presc: got %h tick=%b, want 0 0", t4, tk4);
    end
    step();
    n_vec++;
    if (t4 !== 28'h1 || tk4 !== 1'b1) begin
      n_err++; $display("FAIL reset_presc_full: got %h tick=%b, want 1 1", t4, tk4);
    end
  endtask

  task automatic test_lap();
    do_clear();
    cen = 1'b1;
    repeat (10) step();
    lap = 1'b1;
    step();
    lap = 1'b0;
    repeat (18) step();
`ifdef STOPWATCH_LAP_EN
    n_vec++;
    if (t1 !== 28'h0000010) begin
      n_err++; $display("FAIL lap_hold: got %h, want 0000010", t1);
    end
    lap = 1'b1;
    step();
    lap = 1'b0;
    n_vec++;
    if (t1 !== 28'h0000030) begin
      n_err++; $display("FAIL lap_release: got %h, want 0000030", t1);
    end
`else
    n_vec++;
    if (t1 !== 28'h0000029) begin
      n_err++; $display("FAIL lap_ignored: got %h, want 0000029", t1);
    end
`endif
  endtask

  task automatic test_random();
    logic [27:0] at;
    logic        atk, awr;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 1);
      clr   = ($urandom_range(0, 99) < 3);
      cen   = ($urandom_range(0, 99) < 75);
      lap   = ($urandom_range(0, 99) < 10);
      step();
      for (int k = 0; k < 2; k++) begin
        at  = (k == 0) ? t1 : t4;
        atk = (k == 0) ? tk1 : tk4;
        awr = (k == 0) ? wr1 : wr4;
        n_vec++;
        if (at !== exp_t(k) || atk !== m_tick[k] || awr !== m_wrap[k]) begin
          n_err++;
          $display("FAIL random[%0d] presc=%0d: got %h/%b/%b, want %h/%b/%b",
                   i, presc_of(k), at, atk, awr, exp_t(k), m_tick[k], m_wrap[k]);
        end
      end
    end
    reset = 1'b0; clr = 1'b0; lap = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cen = 1'b0; clr = 1'b0; lap = 1'b0;
    m_lapprev = 1'b0;
    test_reset();
    test_count();
    test_carry_minute();
    test_wrap();
    test_prescale();
    test_clear_reset();
    test_lap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
